dut_bram_capture_ctrl: RTL and testbench

- Downstream stage of the ADC data formatter.
- Consumes the formatter's BRAM-width enable/data stream (16 x 16-bit samples per word) and writes a programmable number of words into an internal inferred block RAM.
- Then serialises the stored words to the USB readout path as 16-bit samples over a valid/ready handshake.
- Provides the arm/capture/readout sequencing for one acquisition.

---
 rtl/dut_bram_capture_ctrl.sv | 130 +++++++++++++
 tb/tb_dut_bram_capture_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_bram_capture_ctrl.sv
// Captures a programmable number of formatter words into block RAM, then streams
// them out as 16-bit samples over a valid/ready handshake for USB readout.
module dut_bram_capture_ctrl #(
  parameter int ADC_MAX_DATA_SIZE = 16,
  parameter int BRAM_WORD_NUM     = 16,
  parameter int BRAM_ADDR_WIDTH   = 10
) (
  input  logic                                       i_dut_format_clk,
  input  logic                                       i_dut_format_reset_n,
  input  logic                                       i_cap_start,
  input  logic                                       i_cap_abort,
  input  logic [BRAM_ADDR_WIDTH-1:0]                 i_cap_depth,
  input  logic                                       i_bram_data_en,
  input  logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0] i_bram_data,
  output logic [ADC_MAX_DATA_SIZE-1:0]               o_rd_data,
  output logic                                       o_rd_valid,
  input  logic                                       i_rd_ready,
  output logic                                       o_busy,
  output logic                                       o_done,
  output logic [BRAM_ADDR_WIDTH:0]                   o_words_captured
);

  localparam int W     = ADC_MAX_DATA_SIZE * BRAM_WORD_NUM;
  localparam int D     = 1 << BRAM_ADDR_WIDTH;
  localparam int IDX_W = (BRAM_WORD_NUM > 1) ? $clog2(BRAM_WORD_NUM) : 1;
  localparam logic [BRAM_ADDR_WIDTH:0] DEPTH_MAX = (BRAM_ADDR_WIDTH+1)'(D);
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(BRAM_WORD_NUM - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, RD_ADDR, RD_LOAD, RD_SHIFT, DONE} state_t;

  state_t                   state_reg;
  logic [BRAM_ADDR_WIDTH:0] depth_reg;
  logic [BRAM_ADDR_WIDTH:0] rd_cnt_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [W-1:0]             word_reg;
  logic [W-1:0]             ram_q;
  logic [W-1:0]             mem [0:D-1];
  logic [ADC_MAX_DATA_SIZE-1:0] samples [0:BRAM_WORD_NUM-1];

  logic [BRAM_ADDR_WIDTH:0]   words_inc;
  logic [BRAM_ADDR_WIDTH-1:0] wr_addr;
  logic [BRAM_ADDR_WIDTH-1:0] rd_addr;
  logic                       wr_en;

  // Word counters double as addresses; their top bit only distinguishes a full-depth count.
  assign words_inc = o_words_captured + 1'b1;
  assign wr_addr   = o_words_captured[BRAM_ADDR_WIDTH-1:0];
  assign rd_addr   = rd_cnt_reg[BRAM_ADDR_WIDTH-1:0];
  assign wr_en     = (state_reg == CAPTURE) && i_bram_data_en && !i_cap_abort;

  genvar gi;
  generate
    for (gi = 0; gi < BRAM_WORD_NUM; gi++) begin : g_sample
      assign samples[gi] = word_reg[gi*ADC_MAX_DATA_SIZE +: ADC_MAX_DATA_SIZE];
    end
  endgenerate

  always_ff @(posedge i_dut_format_clk) begin
    if (wr_en) mem[wr_addr] <= i_bram_data;
    if (state_reg == RD_ADDR) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge i_dut_format_clk or negedge i_dut_format_reset_n) begin
    if (!i_dut_format_reset_n) begin
      state_reg        <= IDLE;
      depth_reg        <= '0;
      rd_cnt_reg       <= '0;
      idx_reg          <= '0;
      word_reg         <= '0;
      o_rd_data        <= '0;
      o_rd_valid       <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_words_captured <= '0;
    end else if (i_cap_abort) begin
      state_reg  <= IDLE;
      o_rd_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (i_cap_start) begin
            state_reg        <= CAPTURE;
            depth_reg        <= (i_cap_depth == '0) ? DEPTH_MAX : {1'b0, i_cap_depth};
            rd_cnt_reg       <= '0;
            o_words_captured <= '0;
            o_done           <= 1'b0;
            o_busy           <= 1'b1;
          end
        end
        CAPTURE: begin
          if (i_bram_data_en) begin
            if (o_words_captured != DEPTH_MAX) o_words_captured <= words_inc;
            if (words_inc == depth_reg) state_reg <= RD_ADDR;
          end
        end
        RD_ADDR: state_reg <= RD_LOAD;
        RD_LOAD: begin
          word_reg   <= ram_q;
          o_rd_data  <= ram_q[ADC_MAX_DATA_SIZE-1:0];
          idx_reg    <= '0;
          rd_cnt_reg <= rd_cnt_reg + 1'b1;
          o_rd_valid <= 1'b1;
          state_reg  <= RD_SHIFT;
        end
        RD_SHIFT: begin
          if (o_rd_valid && i_rd_ready) begin
            if (idx_reg == LAST_IDX) begin
              o_rd_valid <= 1'b0;
              // Compare the word count, since a full-depth read wraps the address to 0.
              if (rd_cnt_reg == depth_reg) begin
                state_reg <= DONE;
                o_busy    <= 1'b0;
                o_done    <= 1'b1;
              end else begin
                state_reg <= RD_ADDR;
              end
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              o_rd_data <= samples[idx_reg + 1'b1];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dut_bram_capture_ctrl.sv
// Directed bench for dut_bram_capture_ctrl: capture depths, readout order, handshake,
// abort and asynchronous reset behaviour, checked against hand-computed values.
module tb_dut_bram_capture_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_cap_start = 1'b0;
  logic         i_cap_abort = 1'b0;
  logic [9:0]   i_cap_depth = '0;
  logic         i_bram_data_en = 1'b0;
  logic [255:0] i_bram_data = '0;
  logic [15:0]  o_rd_data;
  logic         o_rd_valid;
  logic         i_rd_ready = 1'b1;
  logic         o_busy;
  logic         o_done;
  logic [10:0]  o_words_captured;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int stable_err = 0;
  logic        held = 1'b0;
  logic [15:0] held_val = '0;
  logic [15:0] q[$];
  int          qc[$];

  dut_bram_capture_ctrl dut (
    .i_dut_format_clk     (clk),
    .i_dut_format_reset_n (rst_n),
    .i_cap_start          (i_cap_start),
    .i_cap_abort          (i_cap_abort),
    .i_cap_depth          (i_cap_depth),
    .i_bram_data_en       (i_bram_data_en),
    .i_bram_data          (i_bram_data),
    .o_rd_data            (o_rd_data),
    .o_rd_valid           (o_rd_valid),
    .i_rd_ready           (i_rd_ready),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_words_captured     (o_words_captured)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted sample and flag any change of a sample held under backpressure.
  always @(negedge clk) begin
    if (rst_n && o_rd_valid) begin
      if (held && o_rd_data !== held_val) stable_err++;
      if (i_rd_ready) begin
        q.push_back(o_rd_data);
        qc.push_back(cyc);
        held = 1'b0;
      end else begin
        held = 1'b1;
        held_val = o_rd_data;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic logic [255:0] mk(input int base);
    logic [255:0] w;
    for (int k = 0; k < 16; k++) w[16*k +: 16] = 16'(base + k);
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_acq(input logic [9:0] depth, input logic junk_en);
    i_cap_start = 1'b1;
    i_cap_depth = depth;
    i_bram_data_en = junk_en;
    tick;
    i_cap_start = 1'b0;
    i_bram_data_en = 1'b0;
  endtask

  task automatic send(input logic [255:0] word);
    i_bram_data = word;
    i_bram_data_en = 1'b1;
    tick;
    i_bram_data_en = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit bp, input int bound);
    int i = 0;
    while (!o_done && i < bound) begin
      i_rd_ready = bp ? (i % 3 == 0) : 1'b1;
      tick;
      i++;
    end
    i_rd_ready = 1'b1;
    check(tag, o_done, 1);
  endtask

  initial begin
    int c_w;
    int nerr;
    int w;
    bit found;

    // Reset state
    #1;
    check("rst_valid", o_rd_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_data", o_rd_data, 0);
    check("rst_words", o_words_captured, 0);
    tick;
    rst_n = 1'b1;
    tick;

    // Depth 2: samples 0..31, 2-cycle gap between words, valid 2 cycles after capture
    q.delete(); qc.delete();
    start_acq(10'd2, 1'b0);
    check("d2_busy", o_busy, 1);
    send(mk(0));
    c_w = cyc;
    send(mk(16));
    wait_done("d2_done", 1'b0, 200);
    check("d2_count", q.size(), 32);
    nerr = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== 16'(i)) nerr++;
    check("d2_order", nerr, 0);
    if (q.size() == 32) begin
      check("d2_first_lat", qc[0] - c_w, 3);
      check("d2_back2back", qc[1] - qc[0], 1);
      check("d2_gap", qc[16] - qc[15], 3);
    end
    check("d2_words", o_words_captured, 2);
    check("d2_busy_end", o_busy, 0);
    tick; tick;
    check("d2_done_hold", o_done, 1);

    // Depth 0 means full 1024-word capture
    q.delete(); qc.delete();
    start_acq(10'd0, 1'b0);
    for (int j = 0; j < 1024; j++) send(mk(16 * j));
    check("full_words", o_words_captured, 1024);
    wait_done("full_done", 1'b0, 30000);
    check("full_count", q.size(), 16384);
    nerr = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== 16'(i)) nerr++;
    check("full_order", nerr, 0);
    if (q.size() > 0) check("full_last", q[q.size()-1], 16383);

    // Backpressure with ready 1,0,0 repeating
    q.delete(); qc.delete();
    stable_err = 0;
    start_acq(10'd1, 1'b0);
    send(mk(16'hA000));
    wait_done("bp_done", 1'b1, 500);
    check("bp_count", q.size(), 16);
    nerr = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== 16'(16'hA000 + i)) nerr++;
    check("bp_order", nerr, 0);
    check("bp_stable", stable_err, 0);

    // Gapped enables; the enable on the start cycle must be ignored
    q.delete(); qc.delete();
    i_bram_data = mk(16'hDE00);
    start_acq(10'd3, 1'b1);
    w = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 16 == 15) begin
        send(mk(16'h1000 * (w + 1)));
        w++;
      end else begin
        tick;
      end
    end
    wait_done("gap_done", 1'b0, 500);
    check("gap_count", q.size(), 48);
    nerr = 0;
    for (int i = 0; i < q.size(); i++)
      if (q[i] !== 16'(16'h1000 * (i / 16 + 1) + i % 16)) nerr++;
    check("gap_order", nerr, 0);
    check("gap_words", o_words_captured, 3);

    // Abort after 5 of 8 words, with an ignored start pulse mid-capture
    q.delete(); qc.delete();
    start_acq(10'd8, 1'b0);
    for (int j = 0; j < 3; j++) send(mk(16'h200 + 16 * j));
    start_acq(10'd1, 1'b0);
    for (int j = 3; j < 5; j++) send(mk(16'h200 + 16 * j));
    check("ab_words_pre", o_words_captured, 5);
    i_cap_abort = 1'b1;
    tick;
    i_cap_abort = 1'b0;
    check("ab_busy", o_busy, 0);
    check("ab_done", o_done, 0);
    check("ab_valid", o_rd_valid, 0);
    check("ab_words", o_words_captured, 5);
    check("ab_no_rd", q.size(), 0);
    start_acq(10'd1, 1'b0);
    send(mk(16'h500));
    wait_done("ab_re_done", 1'b0, 200);
    check("ab_re_count", q.size(), 16);
    if (q.size() == 16) check("ab_re_last", q[15], 16'h50F);
    check("ab_re_words", o_words_captured, 1);

    // Asynchronous reset while sample 7 is presented
    q.delete(); qc.delete();
    start_acq(10'd1, 1'b0);
    send(mk(16'h300));
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (o_rd_valid && o_rd_data == 16'h307) found = 1'b1;
      else tick;
    end
    check("rs_reach", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_valid", o_rd_valid, 0);
    check("rs_busy", o_busy, 0);
    check("rs_done", o_done, 0);
    check("rs_data", o_rd_data, 0);
    check("rs_words", o_words_captured, 0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) send(mk(16'h700 + i));
    check("rs_idle_busy", o_busy, 0);
    check("rs_idle_valid", o_rd_valid, 0);
    check("rs_idle_words", o_words_captured, 0);
    check("rs_samples", q.size(), 7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
